// File: rtl/ram_requester.sv
// rtl/ram_requester.sv - cpu_ram_if initiator: arbitrates fetch/data requests, one RAM access at a time,
// with RV32 load extraction and an optional BUSY timeout.
module ram_requester #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_store,
  output logic [31:0] d_load,
  output logic        d_done,
  output logic        d_err,
  output logic        busy,
  output logic [31:0] ram_addr,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [1:0]  ram_width,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic [1:0]  ram_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] RAM_DATA  = 2'd2;
  localparam logic [1:0] RAM_ERROR = 2'd3;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        is_data_q, is_data_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_ren_q, ram_ren_d;
  logic        ram_wen_q, ram_wen_d;
  logic [1:0]  ram_width_q, ram_width_d;
  logic [31:0] ram_store_q, ram_store_d;
  logic [31:0] i_data_q, i_data_d;
  logic [31:0] d_load_q, d_load_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        d_err_q, d_err_d;
  logic [31:0] cnt_inc;
  logic        timed_out;
  logic        acc_err;

  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    return (width == 2'b01 && lo[0]) || (width == 2'b10 && lo != 2'b00);
  endfunction

  // Sub-word lane select with sign (funct3[2]=0) or zero (funct3[2]=1) extension.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    is_data_d   = is_data_q;
    wen_d       = wen_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    ram_addr_d  = '0;
    ram_ren_d   = 1'b0;
    ram_wen_d   = 1'b0;
    ram_width_d = '0;
    ram_store_d = '0;
    i_data_d    = i_data_q;
    d_load_d    = d_load_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    cnt_inc     = cnt_q + 32'd1;
    timed_out   = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);
    acc_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (d_req) begin
          is_data_d = 1'b1;
          wen_d     = d_wen;
          funct3_d  = d_funct3;
          addr_lo_d = d_addr[1:0];
          if (misaligned(d_funct3[1:0], d_addr[1:0])) begin
            state_d  = S_DONE;
            d_done_d = 1'b1;
            d_err_d  = 1'b1;
            d_load_d = '0;
          end else begin
            state_d     = S_BUSY;
            ram_addr_d  = {d_addr[31:2], 2'b00};
            ram_width_d = d_funct3[1:0];
            ram_store_d = d_store;
            ram_ren_d   = ~d_wen;
            ram_wen_d   = d_wen;
          end
        end else if (i_req) begin
          is_data_d   = 1'b0;
          wen_d       = 1'b0;
          funct3_d    = 3'b010;
          addr_lo_d   = i_addr[1:0];
          state_d     = S_BUSY;
          ram_addr_d  = {i_addr[31:2], 2'b00};
          ram_width_d = 2'b10;
          ram_ren_d   = 1'b1;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (ram_state == RAM_DATA || ram_state == RAM_ERROR || timed_out) begin
          // Leaving BUSY drops ren/wen so the responder always sees an idle cycle.
          state_d = S_DONE;
          acc_err = (ram_state != RAM_DATA);
          if (is_data_q) begin
            d_done_d = 1'b1;
            d_err_d  = acc_err;
            d_load_d = (acc_err || wen_q) ? 32'd0 : extract(funct3_q, addr_lo_q, ram_load);
          end else begin
            i_done_d = 1'b1;
            if (!acc_err) i_data_d = ram_load;
          end
        end else begin
          ram_addr_d  = ram_addr_q;
          ram_width_d = ram_width_q;
          ram_store_d = ram_store_q;
          ram_ren_d   = ram_ren_q;
          ram_wen_d   = ram_wen_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      is_data_q   <= 1'b0;
      wen_q       <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_width_q <= '0;
      ram_store_q <= '0;
      i_data_q    <= '0;
      d_load_q    <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_data_q   <= is_data_d;
      wen_q       <= wen_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_width_q <= ram_width_d;
      ram_store_q <= ram_store_d;
      i_data_q    <= i_data_d;
      d_load_q    <= d_load_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_width = ram_width_q;
  assign ram_store = ram_store_q;
  assign i_data    = i_data_q;
  assign d_load    = d_load_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;

endmodule

// File: doc/ram_requester.md
Name: ram_requester

Overview:
- CPU-side initiator for the cpu_ram_if protocol: arbitrates instruction-fetch and data (load/store) requests and drives one RAM access at a time over the ram_* signals.
- Waits for the responder to report RAM_DATA, then returns load data with RV32 sub-word extraction and sign/zero extension.
- Sits between the core's fetch/LSU stages and the RAM wrapper.

Parameters:
- TIMEOUT, 16, cycles allowed in BUSY before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request, level, held until i_done
- i_addr  in  32  fetch byte address
- i_data  out  32  fetched word, valid while i_done=1
- i_done  out  1  fetch completion pulse
- d_req  in  1  data request, level, held until d_done
- d_wen  in  1  1=store, 0=load
- d_addr  in  32  data byte address
- d_funct3  in  3  RV32 width: 000 B, 001 H, 010 W, 100 BU, 101 HU
- d_store  in  32  store data, low lanes
- d_load  out  32  extended load result, valid while d_done=1
- d_done  out  1  data completion pulse
- d_err  out  1  with d_done: misaligned access, timeout or RAM_ERROR
- busy  out  1  state != IDLE
- ram_addr  out  32  word-aligned address (low two bits 0)
- ram_ren  out  1  read enable
- ram_wen  out  1  write enable
- ram_width  out  2  00 byte, 01 half, 10 word
- ram_store  out  32  write data
- ram_load  in  32  read data from the responder
- ram_state  in  2  rv32ima_pkg ram state: RAM_FREE, RAM_ADDR, RAM_DATA, RAM_ERROR

Behaviour:
- Reset: state IDLE; all outputs 0, including ram_addr/ram_store, both done pulses, d_err and the timeout counter.
- All ram_* outputs, i_data, d_load, the done pulses and d_err are registered.
- State IDLE:
  - d_req has priority over i_req.
  - On the accepting edge, latch the request (port, wen, funct3, addr, store) and go to BUSY.
  - A data request with a misaligned address goes directly to DONE with d_err=1 and is never issued. Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- State BUSY:
  - Drive ram_addr={addr[31:2],2'b00}, ram_width from funct3[1:0], ram_store=d_store.
  - ram_wen=latched wen; ram_ren=~wen. A fetch always uses ren with width 10.
  - Exactly one of ren/wen is ever high.
  - Increment the timeout counter each cycle.
  - On ram_state==RAM_DATA: capture ram_load, go to DONE.
  - On ram_state==RAM_ERROR, or counter==TIMEOUT with TIMEOUT!=0: go to DONE with err=1.
- State DONE, one cycle:
  - ram_ren=ram_wen=0. This guarantees the responder sees an idle cycle between accesses.
  - Pulse the matching done output; go to IDLE.
- Request handshake: a requester must deassert req in its done cycle. A req still high in the following IDLE cycle is treated as a new request.
- Load extraction, with off=addr[1:0]:
  - B/BU select byte ram_load[8*off+:8], sign- or zero-extended.
  - H/HU select ram_load[16*addr[1]+:16], sign- or zero-extended.
  - W passes the word through.
  - Stores are not shifted; the responder writes low lanes.
- Latency: with a zero-latency responder, DATA is observed 2 cycles after acceptance and done asserts 3 cycles after the accepting edge. Each extra responder latency cycle adds one.
- On error: d_load=0. i_data is undefined, since fetch has no error output; the fetch stage must treat a timeout as fatal.
- Simultaneous i_req and d_req: data is served first; fetch is accepted in the IDLE cycle after d_done.
- Requests arriving while busy are ignored until IDLE.
- nrst low mid-access: immediate return to IDLE with all outputs 0; the in-flight access is dropped without a done pulse.

Test Plan:
- Fetch, zero-latency RAM holding 0xDEADBEEF at 0x100:
  - Stimulus: i_req with i_addr=0x100.
  - Required: ram_ren=1 and ram_addr=0x100 from cycle 1; i_done=1 with i_data=0xDEADBEEF at cycle 3; ren low in the done cycle.
- Loads of word 0x80F17F01 at 0x200:
  - LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080.
  - LH 0x202 -> 0xFFFF80F1; LHU 0x200 -> 0x00007F01.
  - LW 0x200 -> 0x80F17F01.
- Arbitration:
  - i_req and d_req (store) raised in the same cycle -> wen issued first, ren never overlapping it.
  - d_done precedes i_done by 4 cycles (zero-latency RAM).
- Misaligned accesses:
  - LH at 0x201 -> d_done+d_err the cycle after acceptance; ram_ren/ram_wen never assert.
  - SW at 0x202 -> same response.
- Timeout:
  - Stimulus: TIMEOUT=4 with ram_state tied to RAM_ADDR.
  - Required: d_done=1, d_err=1, d_load=0; busy drops the following cycle.
- Reset mid-access:
  - Stimulus: nrst pulsed low during BUSY.
  - Required: all outputs 0 immediately; no done pulse; a new request after reset completes normally.
